shift_arb_ctrl: RTL

Sequencer and arbiter for a shared right-shift (LSB-first) serializer register. Two requesters each present a parallel WIDTH-bit word. The block grants the serializer round-robin, loads the winning word and shifts it out one bit per clock. It then enforces a programmable idle gap before the next frame, and sits between parallel producers and a single serial line.

---
 rtl/shift_arb_ctrl_if.sv | 27 ++
 rtl/shift_arb_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/shift_arb_ctrl_if.sv
// Bundle of request, data and serial-output signals around shift_arb_ctrl.
//   master : the producer/consumer side. It drives req, data0 and data1,
//            and watches grant, owner, busy, sout, sout_valid and done.
//   slave  : the arbiter/serializer itself.
interface shift_arb_ctrl_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       req;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [1:0]       grant;
  logic             owner;
  logic             busy;
  logic             sout;
  logic             sout_valid;
  logic             done;

  modport master (
    output req, data0, data1,
    input  grant, owner, busy, sout, sout_valid, done
  );

  modport slave (
    input  req, data0, data1,
    output grant, owner, busy, sout, sout_valid, done
  );
endinterface

// File: rtl/shift_arb_ctrl.sv
// Round-robin arbiter and LSB-first serializer for two parallel producers.
// The winning word is captured, shifted out one bit per clock, and then an
// idle gap of GAP cycles is inserted before the next arbitration.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : slave side of shift_arb_ctrl_if
//           req/data0/data1 in; grant/owner (registered) and
//           busy/sout/sout_valid/done (decoded from state) out
module shift_arb_ctrl #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  shift_arb_ctrl_if.slave  bus
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    GAP_WAIT = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [BW-1:0]    bitcnt_r;
  logic [GW-1:0]    gapcnt_r;
  logic             last_r;
  logic [1:0]       grant_r;
  logic             owner_r;

  logic             winner_s;
  logic             busy_s;
  logic             sout_s;
  logic             sout_valid_s;
  logic             done_s;

  // Winner selection: a lone request wins outright, a tie goes to the
  // requester that was not served last.
  always_comb begin
    winner_s = 1'b0;
    case (bus.req)
      2'b01:   winner_s = 1'b0;
      2'b10:   winner_s = 1'b1;
      2'b11:   winner_s = ~last_r;
      default: winner_s = 1'b0;
    endcase
  end

  // Sequencer: arbitration, word capture, shifting and inter-frame gap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      shreg_r  <= '0;
      bitcnt_r <= '0;
      gapcnt_r <= '0;
      last_r   <= 1'b1;  // makes requester 0 win the first tie
      grant_r  <= 2'b00;
      owner_r  <= 1'b0;
    end else begin
      grant_r <= 2'b00;
      case (state_r)
        IDLE: begin
          if (bus.req != 2'b00) begin
            shreg_r  <= winner_s ? bus.data1 : bus.data0;
            owner_r  <= winner_s;
            last_r   <= winner_s;
            grant_r  <= winner_s ? 2'b10 : 2'b01;
            bitcnt_r <= '0;
            state_r  <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          shreg_r  <= {1'b0, shreg_r[WIDTH-1:1]};
          bitcnt_r <= bitcnt_r + BW'(1);
          if (bitcnt_r == LAST_BIT) begin
            if (GAP > 0) begin
              state_r  <= GAP_WAIT;
              gapcnt_r <= '0;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            state_r <= SHIFT;
          end
        end
        GAP_WAIT: begin
          gapcnt_r <= gapcnt_r + GW'(1);
          if (gapcnt_r == GAP_LAST) begin
            state_r <= IDLE;
          end else begin
            state_r <= GAP_WAIT;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Status decode, taken from registers only so req/data never reach outputs.
  always_comb begin
    busy_s       = (state_r != IDLE);
    sout_valid_s = (state_r == SHIFT);
    sout_s       = sout_valid_s & shreg_r[0];
    done_s       = sout_valid_s && (bitcnt_r == LAST_BIT);
  end

  assign bus.grant      = grant_r;
  assign bus.owner      = owner_r;
  assign bus.busy       = busy_s;
  assign bus.sout       = sout_s;
  assign bus.sout_valid = sout_valid_s;
  assign bus.done       = done_s;

endmodule
